// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU front end: instruction/address widths,
// the halt opcode, the fetch output-buffer state encoding and a helper that
// recognises the halt opcode in an instruction word.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W = 13;
    localparam int ADDR_W  = 8;

    // Opcode field value [12:9] that stops fetch when the halt feature is built in
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Occupancy of the two-entry fetch output buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // OUT invalid
        ONE   = 2'd1,   // OUT valid, SKID empty
        TWO   = 2'd2    // OUT and SKID valid
    } buf_state_e;

    // True when the opcode field of a 13-bit instruction is the halt opcode
    function automatic logic is_halt_op(input logic [12:0] instr);
        return (instr[12:9] == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// -----------------------------------------------------------------------------
// fetch_skid_buffer
// Two-entry (OUT + SKID) buffer holding instruction + PC pairs between the
// instruction memory and the decoder. OUT feeds the decoder directly; SKID
// catches the one read that can still land while the decoder stalls.
// Popping OUT moves SKID into OUT on the same edge. Flush empties both.
//
// Ports:
//   clk_i         in   clock
//   rst_n_i       in   synchronous active-low reset
//   push_i        in   write push_instr_i/push_pc_i into the buffer
//   push_instr_i  in   instruction payload
//   push_pc_i     in   PC payload
//   pop_i         in   OUT consumed this cycle
//   flush_i       in   drop all entries (overrides push/pop)
//   out_valid_o   out  OUT holds a valid entry
//   out_instr_o   out  OUT instruction (registered)
//   out_pc_o      out  OUT PC (registered)
//   skid_valid_o  out  SKID holds a valid entry
// -----------------------------------------------------------------------------
module fetch_skid_buffer
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 13,
    parameter int ADDR_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [ADDR_W-1:0]  push_pc_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [ADDR_W-1:0]  out_pc_o,
    output logic               skid_valid_o
);

    buf_state_e         r_state;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0]  r_skid_pc;

    buf_state_e         w_state_nxt;
    logic [INSTR_W-1:0] w_out_instr_nxt;
    logic [ADDR_W-1:0]  w_out_pc_nxt;
    logic [INSTR_W-1:0] w_skid_instr_nxt;
    logic [ADDR_W-1:0]  w_skid_pc_nxt;

    // Next-state and payload movement for the OUT/SKID pair
    always_comb begin
        w_state_nxt      = r_state;
        w_out_instr_nxt  = r_out_instr;
        w_out_pc_nxt     = r_out_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        if (flush_i) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (push_i) begin
                        w_out_instr_nxt = push_instr_i;
                        w_out_pc_nxt    = push_pc_i;
                        w_state_nxt     = ONE;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
                ONE: begin
                    if (push_i && pop_i) begin
                        // OUT is replaced in place; occupancy unchanged
                        w_out_instr_nxt = push_instr_i;
                        w_out_pc_nxt    = push_pc_i;
                        w_state_nxt     = ONE;
                    end else if (pop_i) begin
                        w_state_nxt = EMPTY;
                    end else if (push_i) begin
                        w_skid_instr_nxt = push_instr_i;
                        w_skid_pc_nxt    = push_pc_i;
                        w_state_nxt      = TWO;
                    end else begin
                        w_state_nxt = ONE;
                    end
                end
                TWO: begin
                    if (pop_i) begin
                        w_out_instr_nxt = r_skid_instr;
                        w_out_pc_nxt    = r_skid_pc;
                        if (push_i) begin
                            w_skid_instr_nxt = push_instr_i;
                            w_skid_pc_nxt    = push_pc_i;
                            w_state_nxt      = TWO;
                        end else begin
                            w_state_nxt = ONE;
                        end
                    end else begin
                        // The issue rule stops reads while SKID is full, so no push lands here
                        w_state_nxt = TWO;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Buffer state and payload registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= EMPTY;
            r_out_instr  <= {INSTR_W{1'b0}};
            r_out_pc     <= {ADDR_W{1'b0}};
            r_skid_instr <= {INSTR_W{1'b0}};
            r_skid_pc    <= {ADDR_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_out_instr  <= w_out_instr_nxt;
            r_out_pc     <= w_out_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

    assign out_valid_o  = (r_state != EMPTY);
    assign skid_valid_o = (r_state == TWO);
    assign out_instr_o  = r_out_instr;
    assign out_pc_o     = r_out_pc;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Front stage of the 8-bit CPU. Owns the program counter, issues reads to the
// synchronous instruction memory (data one cycle after the strobe), buffers
// returned words in a two-entry skid buffer and presents them to the decoder
// with a valid/ready handshake. A taken branch reported by the decoder for the
// instruction being consumed flushes the buffer and redirects fetch.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   : transferring an instruction with [12:9]=4'b1111 halts fetch
//               until reset (halted_o=1, no reads, instr_valid_o=0)
//   undefined : that opcode is ordinary and halted_o is tied 0
//
// Ports:
//   clk_i          in   clock
//   rst_n_i        in   synchronous active-low reset
//   imem_addr_o    out  instruction memory read address
//   imem_rd_en_o   out  read strobe
//   imem_data_i    in   read data for the previous cycle's strobe
//   instruction_o  out  instruction to decoder
//   instr_pc_o     out  address of instruction_o
//   instr_valid_o  out  instruction_o/instr_pc_o valid
//   instr_ready_i  in   decoder accepts
//   branch_en_i    in   current instruction is a taken branch
//   branch_addr_i  in   branch target
//   halted_o       out  fetch stopped
// -----------------------------------------------------------------------------
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                INSTR_W  = 13,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic               imem_rd_en_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    input  logic               branch_en_i,
    input  logic [ADDR_W-1:0]  branch_addr_i,
    output logic               halted_o
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;
    logic              r_pending;
    logic [ADDR_W-1:0] r_pend_pc;

    logic w_xfer;
    logic w_halt_xfer;
    logic w_halted;
    logic w_branch;
    logic w_issue;
    logic w_push;
    logic w_skid_valid;

    assign w_xfer = instr_valid_o & instr_ready_i;

`ifdef FETCH_HALT_EN
    logic r_halted;

    assign w_halt_xfer = w_xfer & is_halt_op(instruction_o);
    assign w_halted    = r_halted;

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_halted <= 1'b0;
        end else if (w_halt_xfer) begin
            r_halted <= 1'b1;
        end else begin
            r_halted <= r_halted;
        end
    end
`else
    assign w_halt_xfer = 1'b0;
    assign w_halted    = 1'b0;
`endif

    // A halt on the same transfer takes precedence over the branch
    assign w_branch = w_xfer & branch_en_i & ~w_halt_xfer;

    // Stop issuing when SKID is full, or when the read already in flight will
    // have to go into SKID because OUT is stalled; this bounds occupancy at two.
    assign w_issue = ~w_halted & ~w_skid_valid &
                     ~(r_pending & instr_valid_o & ~instr_ready_i);

    // Returning data is dropped when the stream is being redirected or halted
    assign w_push = r_pending & ~w_branch & ~w_halt_xfer;

    assign imem_rd_en_o = rst_n_i & (w_branch | w_issue);
    assign imem_addr_o  = (!rst_n_i) ? RESET_PC :
                          (w_branch  ? branch_addr_i : r_pc);

    // PC and in-flight read tracking
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pc      <= RESET_PC;
            r_pending <= 1'b0;
            r_pend_pc <= {ADDR_W{1'b0}};
        end else if (w_halt_xfer) begin
            r_pc      <= r_pc;
            r_pending <= 1'b0;
            r_pend_pc <= r_pend_pc;
        end else if (w_branch) begin
            r_pc      <= branch_addr_i + PC_ONE;
            r_pending <= 1'b1;
            r_pend_pc <= branch_addr_i;
        end else if (w_issue) begin
            r_pc      <= r_pc + PC_ONE;
            r_pending <= 1'b1;
            r_pend_pc <= r_pc;
        end else begin
            r_pc      <= r_pc;
            r_pending <= 1'b0;
            r_pend_pc <= r_pend_pc;
        end
    end

    fetch_skid_buffer #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .push_i       (w_push),
        .push_instr_i (imem_data_i),
        .push_pc_i    (r_pend_pc),
        .pop_i        (w_xfer),
        .flush_i      (w_branch | w_halt_xfer),
        .out_valid_o  (instr_valid_o),
        .out_instr_o  (instruction_o),
        .out_pc_o     (instr_pc_o),
        .skid_valid_o (w_skid_valid)
    );

    assign halted_o = w_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. A behavioural ROM returns
// 13'h0100 + addr one cycle after each strobe (13'h1E00 at address 2 once
// halt_mode is set). Halt expectations follow FETCH_HALT_EN.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  imem_addr_o;
    logic        imem_rd_en_o;
    logic [12:0] imem_data_i = 13'h0000;
    logic [12:0] instruction_o;
    logic [7:0]  instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        branch_en_i;
    logic [7:0]  branch_addr_i;
    logic        halted_o;

    logic        halt_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          reads  = 0;
    int          r0;

    always #5 clk_i = ~clk_i;

    instruction_fetch #(
        .INSTR_W  (13),
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_en_o  (imem_rd_en_o),
        .imem_data_i   (imem_data_i),
        .instruction_o (instruction_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .branch_en_i   (branch_en_i),
        .branch_addr_i (branch_addr_i),
        .halted_o      (halted_o)
    );

    function automatic logic [12:0] rom(input logic [7:0] a, input logic hm);
        if (hm && (a == 8'h02)) return 13'h1E00;
        return 13'h0100 + {5'b00000, a};
    endfunction

    // Synchronous ROM: data for the strobed address one cycle later
    always @(posedge clk_i) begin
        if (imem_rd_en_o) imem_data_i <= rom(imem_addr_o, halt_mode);
    end

    // Count issued reads
    always @(posedge clk_i) begin
        if (rst_n_i === 1'b1 && imem_rd_en_o === 1'b1) reads <= reads + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
        chk({tag, "_pc"}, {24'd0, instr_pc_o}, {24'd0, pc});
        chk({tag, "_instr"}, {19'd0, instruction_o}, {19'd0, rom(pc, halt_mode)});
    endtask

    initial begin
        rst_n_i       = 1'b0;
        instr_ready_i = 1'b1;
        branch_en_i   = 1'b0;
        branch_addr_i = 8'h00;
        #1;
        chk("rst_rd_en", {31'd0, imem_rd_en_o}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr_o}, 32'h00);
        tick();
        tick();
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", {19'd0, instruction_o}, 32'h0);
        chk("rst_pc", {24'd0, instr_pc_o}, 32'h0);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);

        // c0: first read of RESET_PC
        rst_n_i = 1'b1;
        #1;
        chk("c0_rd_en", {31'd0, imem_rd_en_o}, 32'd1);
        chk("c0_addr", {24'd0, imem_addr_o}, 32'h00);
        chk("c0_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("c1_addr", {24'd0, imem_addr_o}, 32'h01);
        chk("c1_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk_out("c2", 8'h00);
        chk("c2_addr", {24'd0, imem_addr_o}, 32'h02);
        tick();
        chk_out("c3", 8'h01);
        tick();
        chk_out("c4", 8'h02);

        // Stall for five cycles with PC 3 presented
        tick();
        chk_out("c5", 8'h03);
        instr_ready_i = 1'b0;
        #1;
        chk("stall_rd_en", {31'd0, imem_rd_en_o}, 32'd0);
        r0 = reads;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("stall_hold", 8'h03);
            chk("stall_hold_rd_en", {31'd0, imem_rd_en_o}, 32'd0);
        end
        tick();
        instr_ready_i = 1'b1;
        #1;
        chk_out("c10", 8'h03);
        chk("c10_rd_en_skid_full", {31'd0, imem_rd_en_o}, 32'd0);
        chk("stall_no_reads", reads - r0, 32'd0);
        tick();
        chk_out("c11", 8'h04);
        chk("c11_rd_en", {31'd0, imem_rd_en_o}, 32'd1);
        chk("c11_addr", {24'd0, imem_addr_o}, 32'h05);
        tick();
        chk("c12_bubble", {31'd0, instr_valid_o}, 32'd0);

        // Taken branch at PC 5 to 8'h40
        tick();
        chk_out("c13", 8'h05);
        branch_en_i   = 1'b1;
        branch_addr_i = 8'h40;
        #1;
        chk("br_rd_en", {31'd0, imem_rd_en_o}, 32'd1);
        chk("br_addr", {24'd0, imem_addr_o}, 32'h40);
        tick();
        branch_en_i = 1'b0;
        #1;
        chk("br_bubble", {31'd0, instr_valid_o}, 32'd0);
        chk("br_next_addr", {24'd0, imem_addr_o}, 32'h41);
        tick();
        chk_out("br_target", 8'h40);

        // Branch indication without ready is ignored
        instr_ready_i = 1'b0;
        branch_en_i   = 1'b1;
        branch_addr_i = 8'h80;
        #1;
        chk("nobr_rd_en", {31'd0, imem_rd_en_o}, 32'd0);
        chk("nobr_addr", {24'd0, imem_addr_o}, 32'h42);
        tick();
        instr_ready_i = 1'b1;
        branch_en_i   = 1'b0;
        #1;
        chk_out("nobr_hold", 8'h40);
        tick();
        chk_out("nobr_seq41", 8'h41);
        tick();
        chk("nobr_bubble", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk_out("nobr_seq42", 8'h42);

        // Branch to 8'hFE then wrap FE, FF, 00
        branch_en_i   = 1'b1;
        branch_addr_i = 8'hFE;
        #1;
        chk("wrap_br_addr", {24'd0, imem_addr_o}, 32'hFE);
        tick();
        branch_en_i = 1'b0;
        #1;
        chk("wrap_bubble", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk_out("wrap_fe", 8'hFE);
        tick();
        chk_out("wrap_ff", 8'hFF);
        tick();
        chk_out("wrap_00", 8'h00);
        chk("wrap_addr", {24'd0, imem_addr_o}, 32'h02);

        // Mid-run reset, then restart with halt opcode at PC 2
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_rd_en", {31'd0, imem_rd_en_o}, 32'd0);
        tick();
        chk("mid_rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("mid_rst_halted", {31'd0, halted_o}, 32'd0);
        halt_mode = 1'b1;
        rst_n_i   = 1'b1;
        #1;
        chk("restart_rd_en", {31'd0, imem_rd_en_o}, 32'd1);
        chk("restart_addr", {24'd0, imem_addr_o}, 32'h00);
        tick();
        tick();
        chk_out("restart_pc0", 8'h00);
        tick();
        chk_out("restart_pc1", 8'h01);
        tick();
        chk_out("halt_instr", 8'h02);
        tick();
`ifdef FETCH_HALT_EN
        chk("halt_halted", {31'd0, halted_o}, 32'd1);
        chk("halt_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("halt_rd_en", {31'd0, imem_rd_en_o}, 32'd0);
        r0 = reads;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_stay_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("halt_stay_halted", {31'd0, halted_o}, 32'd1);
        end
        chk("halt_no_reads", reads - r0, 32'd0);
`else
        chk("nohalt_halted", {31'd0, halted_o}, 32'd0);
        chk_out("nohalt_pc3", 8'h03);
        chk("nohalt_rd_en", {31'd0, imem_rd_en_o}, 32'd1);
`endif

        // Reset clears halt and restarts at RESET_PC
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        #1;
        chk("final_halted", {31'd0, halted_o}, 32'd0);
        chk("final_rd_en", {31'd0, imem_rd_en_o}, 32'd1);
        chk("final_addr", {24'd0, imem_addr_o}, 32'h00);
        tick();
        tick();
        chk_out("final_pc0", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front stage of the 8-bit CPU: owns the program counter, issues reads to the synchronous instruction memory, and presents 13-bit instructions to the instruction decoder with a valid/ready handshake. It absorbs downstream stalls with a two-entry output buffer and redirects the PC on the branch indication that the decoder produces for the instruction currently being consumed.

## Interface
Parameters:
- INSTR_W, 13, instruction width
- ADDR_W, 8, program address width
- RESET_PC, 8'h00, first fetch address after reset

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- imem_addr_o  out  ADDR_W  instruction memory read address
- imem_rd_en_o  out  1  read strobe; data returned exactly one cycle later
- imem_data_i  in  INSTR_W  read data for the read strobed in the previous cycle
- instruction_o  out  INSTR_W  instruction to decoder
- instr_pc_o  out  ADDR_W  address of instruction_o
- instr_valid_o  out  1  instruction_o/instr_pc_o valid
- instr_ready_i  in  1  decoder accepts; transfer when valid & ready
- branch_en_i  in  1  decoder: instruction_o is a taken branch
- branch_addr_i  in  ADDR_W  branch target
- halted_o  out  1  fetch stopped (FETCH_HALT_EN only)

## Operation
- Registers: pc_q (next fetch address), pending_q (read in flight, plus its address), output entry OUT, skid entry SKID.
- Buffer FSM: EMPTY (OUT invalid), ONE (OUT valid, SKID empty), TWO (both valid). Transfer pops OUT; SKID moves to OUT in the same edge.
- Arriving data (pending_q=1) goes to OUT if OUT is empty or being popped and SKID empty; else to SKID.
- Issue rule: imem_rd_en_o=1 iff not halted, SKID empty, and not (pending_q & instr_valid_o & ~instr_ready_i). Issue drives imem_addr_o=pc_q, pc_q<=pc_q+1, pending_q<=1. This guarantees SKID never overflows.
- PC arithmetic modulo 2^ADDR_W: 8'hFF increments to 8'h00.
- Branch: honoured only when instr_valid_o & instr_ready_i & branch_en_i; ignored otherwise. In that cycle: SKID and OUT are flushed, data arriving this cycle is discarded, imem_addr_o=branch_addr_i with imem_rd_en_o=1 (regardless of issue rule), pc_q<=branch_addr_i+1, pending_q<=1.
- Branch while halted: not possible (see Configuration).
- Reset: applies on any edge with rst_n_i=0, mid-operation included; in-flight read discarded.

## Timing
- Reset values: pc_q=RESET_PC, pending_q=0, instr_valid_o=0, instruction_o=0, instr_pc_o=0, SKID empty, halted_o=0, imem_rd_en_o=0 during reset, imem_addr_o=RESET_PC.
- First cycle after reset release (c0): read of RESET_PC issued; c1 data arrives; c2 instr_valid_o=1.
- Steady state with ready held high: one instruction per cycle, fetch-to-output latency 2 cycles.
- Taken branch accepted in cycle t: one bubble (instr_valid_o=0 in t+1), target valid in t+2.
- Stall: instr_ready_i low holds instruction_o/instr_pc_o stable; at most one further instruction is buffered; no reads issued while SKID full.

## Configuration
- FETCH_HALT_EN defined: an instruction with bits [12:9]=4'b1111, when transferred, sets halted_o=1 on the next edge; no further reads, pending data discarded, buffers flushed, instr_valid_o=0 until reset. Branch on the same transfer is ignored (halt wins).
- Not defined: 4'b1111 is an ordinary instruction; halted_o tied 0.

## Structure
- Shared package cpu_pkg: INSTR_W, ADDR_W, OP_HALT (4'b1111), buffer state enum {EMPTY, ONE, TWO}.
- One sub-module: fetch_skid_buffer (OUT/SKID two-entry buffer with push, pop, flush; instruction+PC payload). PC, issue and branch logic stay in instruction_fetch.

## Test plan
- Reset release, ROM word at addr n = 13'h0100+n, ready=1 -> imem_addr_o 0,1,2… from c0; instr_valid_o first high at c2 with instruction_o=13'h0100, instr_pc_o=0; then one per cycle.
- Ready low 5 cycles after PC 3 presented -> instruction_o stays PC 3, exactly one extra read (PC 4); on ready high PCs 3,4,5 appear in order, none lost or repeated.
- Branch accepted at PC 5 to target 8'h40 -> imem_addr_o=8'h40 same cycle, one bubble, next valid instr_pc_o=8'h40, PC 6 never presented.
- branch_en_i=1 with instr_ready_i=0 -> no redirect; sequence continues.
- Sequential run from 8'hFE -> instr_pc_o FE, FF, 00.
- With FETCH_HALT_EN, 13'h1E00 at PC 2 transferred -> halted_o=1 next cycle, no further reads or valids; rst_n_i low one cycle mid-run -> restart at RESET_PC, halted_o=0.
